// File: rtl/skinny_sbox_layer_cms1_ctrl.sv
// Serialises a 2-share 16-byte SKINNY state through one shared CMS1 S-box,
// one byte per randomness handshake, and reassembles the substituted shares.
module skinny_sbox_layer_cms1_ctrl #(
    parameter int NBYTES = 16,
    parameter int RW     = 76
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] in_s0,
    input  logic [8*NBYTES-1:0] in_s1,
    input  logic [RW-1:0]       rnd,
    input  logic                rnd_valid,
    output logic                rnd_ready,
    output logic [7:0]          sb_si0,
    output logic [7:0]          sb_si1,
    output logic [RW-1:0]       sb_r,
    input  logic [7:0]          sb_bo0,
    input  logic [7:0]          sb_bo1,
    output logic [8*NBYTES-1:0] out_s0,
    output logic [8*NBYTES-1:0] out_s1,
    output logic                busy,
    output logic                done
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t        r_state;
    logic [W-1:0]  r_sh0;
    logic [W-1:0]  r_sh1;
    logic [W-1:0]  r_out0;
    logic [W-1:0]  r_out1;
    logic [CW-1:0] r_feed_cnt;
    logic [CW-1:0] r_cap_cnt;
    logic          r_cap_v;
    logic          r_rnd_ready;
    logic          r_busy;
    logic          r_done;
    logic          w_fire;

    // Without fresh randomness the S-box sees all-zero inputs, never stale shares
    assign w_fire    = rnd_valid & r_rnd_ready;
    assign sb_si0    = w_fire ? r_sh0[W-1 -: 8] : 8'h00;
    assign sb_si1    = w_fire ? r_sh1[W-1 -: 8] : 8'h00;
    assign sb_r      = w_fire ? rnd : '0;
    assign rnd_ready = r_rnd_ready;
    assign out_s0    = r_out0;
    assign out_s1    = r_out1;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_out0      <= '0;
            r_out1      <= '0;
            r_feed_cnt  <= '0;
            r_cap_cnt   <= '0;
            r_cap_v     <= 1'b0;
            r_rnd_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cap_v <= w_fire;
            r_done  <= 1'b0;
            // S-box output lands one cycle after the byte that produced it
            if (r_cap_v) begin
                r_out0    <= {r_out0[W-9:0], sb_bo0};
                r_out1    <= {r_out1[W-9:0], sb_bo1};
                r_cap_cnt <= r_cap_cnt + 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sh0       <= in_s0;
                        r_sh1       <= in_s1;
                        r_feed_cnt  <= '0;
                        r_cap_cnt   <= '0;
                        r_rnd_ready <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= FEED;
                    end
                end
                FEED: begin
                    if (w_fire) begin
                        r_sh0      <= {r_sh0[W-9:0], 8'h00};
                        r_sh1      <= {r_sh1[W-9:0], 8'h00};
                        r_feed_cnt <= r_feed_cnt + 1'b1;
                        if (r_feed_cnt == LAST) begin
                            r_rnd_ready <= 1'b0;
                            r_state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (r_cap_v && (r_cap_cnt == LAST)) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
